vga_text_overlay: RTL and testbench

Parametrised text renderer for the VGA title and status lines. Holds a writable line of glyph codes and a built-in 8×16 font ROM with the "Starflux" glyph set, and turns a streamed pixel coordinate into a 1-bit foreground pixel through a fixed 3-cycle pipeline. Adds runtime placement, integer scaling and blinking. Sits between the VGA timing generator and the colour mux.

---
 rtl/vga_text_overlay.sv | 159 +++++++++++++++
 tb/tb_vga_text_overlay.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_overlay.sv
// vga_text_overlay: renders one line of glyph codes from a built-in 8x16 font
// as a 1-bit foreground pixel stream. The text box can be placed and scaled at
// run time, and the whole line can blink. The pipeline is fixed at 3 cycles.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   text_we/text_waddr/text_wdata text buffer write port
//   frame_start                   frame pulse; captures origin/scale/blink_en
//   origin_x, origin_y            top-left corner of the text box
//   scale                         log2 magnification (3 behaves as 2)
//   blink_en                      blank every other 2^BLINK_BIT frames
//   pix_valid, pix_x, pix_y       streamed pixel coordinate
//   out_valid, out_on             pixel result, 3 cycles after the input
module vga_text_overlay #(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9,
  parameter int unsigned BLINK_BIT = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         text_we,
  input  logic [$clog2(MAX_CHARS)-1:0] text_waddr,
  input  logic [CODE_W-1:0]            text_wdata,
  input  logic                         frame_start,
  input  logic [X_W-1:0]               origin_x,
  input  logic [Y_W-1:0]               origin_y,
  input  logic [1:0]                   scale,
  input  logic                         blink_en,
  input  logic                         pix_valid,
  input  logic [X_W-1:0]               pix_x,
  input  logic [Y_W-1:0]               pix_y,
  output logic                         out_valid,
  output logic                         out_on
);

  localparam int unsigned CHAR_W = $clog2(MAX_CHARS);
  // Box limits are compared at a width that holds MAX_CHARS*8<<2.
  localparam int unsigned BX_W   = X_W + 8;
  localparam int unsigned BY_W   = Y_W + 3;

  // One row of the "Starflux" font; row 0 is the most significant byte.
  function automatic logic [7:0] font_row(input logic [2:0] g, input logic [3:0] r);
    logic [127:0] bits;
    case (g)
      3'd0:    bits = 128'h00007CC6C660380C06C6C67C00000000; // S
      3'd1:    bits = 128'h00001030301530303030361C00000000; // t
      3'd2:    bits = 128'h0000000000780C7CCCCCCC7600000000; // a
      3'd3:    bits = 128'h0000000000DC7666606060F000000000; // r
      3'd4:    bits = 128'h00001C36323078303030307800000000; // f
      3'd5:    bits = 128'h00003818181818181818183C00000000; // l
      3'd6:    bits = 128'h0000000000CCCCCCCCCCCC7600000000; // u
      default: bits = 128'h0000000000C66C3838386CC600000000; // x
    endcase
    return bits[8'd127 - {1'b0, r, 3'b000} -: 8];
  endfunction

  // Frame registers
  logic [X_W-1:0]    ox_q;
  logic [Y_W-1:0]    oy_q;
  logic [1:0]        s_q;
  logic              blink_q;
  logic [7:0]        frame_cnt_q;
  logic [CODE_W-1:0] text_q [MAX_CHARS];

  // Pipeline registers
  logic              v1_q, lit1_q;
  logic [2:0]        col1_q;
  logic [3:0]        row1_q;
  logic [CODE_W-1:0] code1_q;
  logic              v2_q, lit2_q;
  logic [2:0]        col2_q;
  logic [3:0]        row2_q;
  logic [2:0]        glyph2_q;
  logic              out_valid_q, out_on_q;

  // Stage-1 next values
  logic [X_W:0]      rx;
  logic [Y_W:0]      ry;
  logic [BX_W-1:0]   box_w;
  logic [BY_W-1:0]   box_h;
  logic              lit1_d;
  logic [2:0]        col1_d;
  logic [3:0]        row1_d;
  logic [CHAR_W-1:0] char_d;
  logic [7:0]        rom_row;
  logic              pix_bit;

  // Box geometry; the top bit of rx/ry is the borrow of the subtraction.
  always_comb begin
    rx      = {1'b0, pix_x} - {1'b0, ox_q};
    ry      = {1'b0, pix_y} - {1'b0, oy_q};
    box_w   = BX_W'(MAX_CHARS * 8) << s_q;
    box_h   = BY_W'(16) << s_q;
    lit1_d  = !rx[X_W] && !ry[Y_W]
              && (BX_W'(rx[X_W-1:0]) < box_w)
              && (BY_W'(ry[Y_W-1:0]) < box_h)
              && !(blink_q && frame_cnt_q[BLINK_BIT]);
    col1_d  = 3'(rx[X_W-1:0] >> s_q);
    row1_d  = 4'(ry[Y_W-1:0] >> s_q);
    char_d  = CHAR_W'((rx[X_W-1:0] >> s_q) >> 3);
    rom_row = font_row(glyph2_q, row2_q);
    pix_bit = rom_row[3'd7 - col2_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ox_q        <= '0;
      oy_q        <= '0;
      s_q         <= '0;
      blink_q     <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < int'(MAX_CHARS); i++)
        text_q[i] <= (i < 8) ? CODE_W'(i) : '1;
      v1_q        <= 1'b0;
      lit1_q      <= 1'b0;
      col1_q      <= '0;
      row1_q      <= '0;
      code1_q     <= '0;
      v2_q        <= 1'b0;
      lit2_q      <= 1'b0;
      col2_q      <= '0;
      row2_q      <= '0;
      glyph2_q    <= '0;
      out_valid_q <= 1'b0;
      out_on_q    <= 1'b0;
    end else begin
      if (text_we) text_q[text_waddr] <= text_wdata;
      if (frame_start) begin
        ox_q        <= origin_x;
        oy_q        <= origin_y;
        s_q         <= (scale == 2'd3) ? 2'd2 : scale;
        blink_q     <= blink_en;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      // Stage 1: the code is sampled with the coordinate, so a write in the
      // same cycle (or the next one) leaves this pixel on the old code.
      v1_q     <= pix_valid;
      lit1_q   <= lit1_d;
      col1_q   <= col1_d;
      row1_q   <= row1_d;
      code1_q  <= text_q[char_d];
      // Stage 2: codes >= 8 are blank.
      v2_q     <= v1_q;
      lit2_q   <= lit1_q && (code1_q < CODE_W'(8));
      col2_q   <= col1_q;
      row2_q   <= row1_q;
      glyph2_q <= code1_q[2:0];
      // Stage 3: font lookup.
      out_valid_q <= v2_q;
      out_on_q    <= v2_q && lit2_q && pix_bit;
    end
  end

  assign out_valid = out_valid_q;
  assign out_on    = out_on_q;

endmodule

// File: tb/tb_vga_text_overlay.sv
// Self-checking bench for vga_text_overlay: a behavioural model predicts every
// output cycle, plus a table of hand-derived pixels and corner-case sequences.
module tb_vga_text_overlay;
  localparam int unsigned MAX_CHARS = 16;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned BLINK_BIT = 5;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         text_we;
  logic [$clog2(MAX_CHARS)-1:0] text_waddr;
  logic [CODE_W-1:0]            text_wdata;
  logic                         frame_start;
  logic [X_W-1:0]               origin_x;
  logic [Y_W-1:0]               origin_y;
  logic [1:0]                   scale;
  logic                         blink_en;
  logic                         pix_valid;
  logic [X_W-1:0]               pix_x;
  logic [Y_W-1:0]               pix_y;
  logic                         out_valid;
  logic                         out_on;

  always #5 clk = ~clk;

  vga_text_overlay #(
    .MAX_CHARS(MAX_CHARS), .CODE_W(CODE_W), .X_W(X_W), .Y_W(Y_W), .BLINK_BIT(BLINK_BIT)
  ) dut (
    .clk(clk), .reset(reset), .text_we(text_we), .text_waddr(text_waddr),
    .text_wdata(text_wdata), .frame_start(frame_start), .origin_x(origin_x),
    .origin_y(origin_y), .scale(scale), .blink_en(blink_en), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .out_valid(out_valid), .out_on(out_on)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference font: 16 rows per glyph, row 0 first.
  function automatic logic [127:0] glyph(input int g);
    case (g)
      0: return 128'h00007CC6C660380C06C6C67C00000000;
      1: return 128'h00001030301530303030361C00000000;
      2: return 128'h0000000000780C7CCCCCCC7600000000;
      3: return 128'h0000000000DC7666606060F000000000;
      4: return 128'h00001C36323078303030307800000000;
      5: return 128'h00003818181818181818183C00000000;
      6: return 128'h0000000000CCCCCCCCCCCC7600000000;
      default: return 128'h0000000000C66C3838386CC600000000;
    endcase
  endfunction

  // Behavioural model state
  int m_text [MAX_CHARS];
  int m_ox, m_oy, m_s, m_cnt;
  bit m_blink;
  bit hv [3];
  bit ho [3];

  task automatic model_reset();
    for (int i = 0; i < int'(MAX_CHARS); i++) m_text[i] = (i < 8) ? i : (1 << CODE_W) - 1;
    m_ox = 0; m_oy = 0; m_s = 0; m_cnt = 0; m_blink = 0;
  endtask

  function automatic bit model_on(input int x, input int y);
    int rx, ry, u, c, col, row, code;
    logic [127:0] g;
    logic [7:0] b;
    rx = x - m_ox;
    ry = y - m_oy;
    if (rx < 0 || ry < 0) return 0;
    if (rx >= (int'(MAX_CHARS) * 8) * (1 << m_s) || ry >= 16 * (1 << m_s)) return 0;
    u    = rx / (1 << m_s);
    c    = u / 8;
    col  = u % 8;
    row  = (ry / (1 << m_s)) % 16;
    code = m_text[c];
    if (code >= 8) return 0;
    if (m_blink && ((m_cnt / (1 << BLINK_BIT)) % 2) == 1) return 0;
    g = glyph(code);
    b = g[127 - 8*row -: 8];
    return b[7 - col];
  endfunction

  // One clock: predict this cycle's pixel, advance, compare the output stream.
  task automatic step();
    bit nv, no;
    if (reset) begin
      nv = 0; no = 0;
      model_reset();
      for (int i = 0; i < 3; i++) begin hv[i] = 0; ho[i] = 0; end
    end else begin
      nv = pix_valid;
      no = pix_valid && model_on(int'(pix_x), int'(pix_y));
      if (text_we) m_text[text_waddr] = int'(text_wdata);
      if (frame_start) begin
        m_ox = int'(origin_x); m_oy = int'(origin_y);
        m_s = (scale == 2'd3) ? 2 : int'(scale);
        m_blink = blink_en;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = nv;
    ho[2] = ho[1]; ho[1] = ho[0]; ho[0] = no;
    @(posedge clk);
    #1;
    check("model_valid", out_valid, hv[2]);
    check("model_on", out_on, ho[2]);
  endtask

  task automatic clear_strobes();
    frame_start = 0; text_we = 0;
  endtask

  task automatic set_frame(input int ox, input int oy, input int s, input bit bl);
    frame_start = 1; origin_x = X_W'(ox); origin_y = Y_W'(oy);
    scale = 2'(s); blink_en = bl; pix_valid = 0;
    step();
    clear_strobes();
  endtask

  task automatic write_slot(input int slot, input int code);
    text_we = 1; text_waddr = 4'(slot); text_wdata = CODE_W'(code); pix_valid = 0;
    step();
    clear_strobes();
  endtask

  // Present one pixel on an idle pipeline and check it exactly 3 cycles later.
  task automatic pix_check(input string name, input int x, input int y, input bit exp);
    pix_valid = 1; pix_x = X_W'(x); pix_y = Y_W'(y);
    step();
    clear_strobes();
    pix_valid = 0;
    step();
    check({name, "_lat"}, out_valid, 1'b0);
    step();
    check({name, "_valid"}, out_valid, 1'b1);
    check(name, out_on, exp);
  endtask

  typedef struct {
    int x;
    int y;
    bit exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Origin (100,50), scale 0, default "Starflux" line.
    tbl[0]  = '{99, 55, 1'b0};   tbl[1]  = '{228, 55, 1'b0};
    tbl[2]  = '{111, 55, 1'b1};  tbl[3]  = '{113, 55, 1'b1};
    tbl[4]  = '{115, 55, 1'b1};  tbl[5]  = '{108, 55, 1'b0};
    tbl[6]  = '{112, 55, 1'b0};  tbl[7]  = '{101, 52, 1'b1};
    tbl[8]  = '{105, 52, 1'b1};  tbl[9]  = '{100, 52, 1'b0};
    tbl[10] = '{106, 52, 1'b0};  tbl[11] = '{165, 52, 1'b0};
    tbl[12] = '{101, 66, 1'b0};  tbl[13] = '{101, 49, 1'b0};
    tbl[14] = '{117, 57, 1'b1};

    reset = 1; text_we = 0; text_waddr = '0; text_wdata = '0; frame_start = 0;
    origin_x = '0; origin_y = '0; scale = '0; blink_en = 0;
    pix_valid = 0; pix_x = '0; pix_y = '0;
    model_reset();
    step();
    step();
    check("reset_valid", out_valid, 1'b0);
    check("reset_on", out_on, 1'b0);
    reset = 0;

    // Default line
    set_frame(100, 50, 0, 0);
    for (int i = 0; i < 15; i++)
      pix_check($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].exp);

    // Write / blank
    write_slot(0, 9);
    pix_check("blank_slot0", 101, 52, 1'b0);
    text_we = 1; text_waddr = 4'd0; text_wdata = 4'd0;
    pix_valid = 1; pix_x = 10'd101; pix_y = 9'd52;
    step();
    clear_strobes();
    step();
    pix_valid = 0;
    step();
    check("wr_same_cycle_old", out_on, 1'b0);
    step();
    check("wr_next_cycle_new", out_on, 1'b1);

    // Mid-frame origin change has no effect until frame_start
    origin_x = 10'd0; origin_y = 9'd0;
    pix_check("mid_keep", 101, 52, 1'b1);
    pix_check("mid_ignored", 1, 2, 1'b0);
    frame_start = 1; scale = 2'd0; blink_en = 0;
    pix_valid = 1; pix_x = 10'd101; pix_y = 9'd52;
    step();
    clear_strobes();
    pix_x = 10'd1; pix_y = 9'd2;
    step();
    pix_valid = 0;
    step();
    check("fs_same_cycle_old", out_on, 1'b1);
    step();
    check("fs_next_cycle_new", out_on, 1'b1);

    // Scaling
    set_frame(0, 0, 2, 0);
    pix_check("s2_start", 4, 8, 1'b1);
    pix_check("s2_end", 23, 11, 1'b1);
    pix_check("s2_left", 3, 8, 1'b0);
    pix_check("s2_right", 24, 8, 1'b0);
    pix_check("s2_above", 4, 7, 1'b0);
    write_slot(15, 1);
    pix_check("s2_box_last_x", 511, 20, 1'b1);
    pix_check("s2_box_past_x", 512, 20, 1'b0);
    pix_check("s2_box_past_y", 511, 64, 1'b0);
    set_frame(0, 0, 3, 0);
    pix_check("s3_as_s2", 4, 8, 1'b1);

    // Reset with pixels in flight
    write_slot(0, 9);
    set_frame(100, 50, 0, 0);
    pix_valid = 1; pix_x = 10'd101; pix_y = 9'd52; step();
    pix_x = 10'd105; step();
    pix_x = 10'd111; pix_y = 9'd55; step();
    pix_valid = 0; reset = 1;
    step();
    check("rst_drop0", out_valid, 1'b0);
    reset = 0;
    step();
    check("rst_drop1", out_valid, 1'b0);
    step();
    check("rst_drop2", out_valid, 1'b0);
    set_frame(100, 50, 0, 0);
    pix_check("rst_text_S", 101, 52, 1'b1);
    pix_check("rst_text_t", 111, 55, 1'b1);

    // Blink: frame counter starts at 0 after reset
    reset = 1; step(); reset = 0;
    for (int f = 1; f <= 300; f++) begin
      set_frame(100, 50, 0, 1);
      if (f == 1 || f == 31 || f == 32 || f == 63 || f == 64 || f == 95 ||
          f == 96 || f == 255 || f == 256 || f == 288)
        pix_check($sformatf("blink_f%0d", f), 101, 52, (((f % 256) / 32) % 2) == 0);
    end
    set_frame(100, 50, 0, 0);
    pix_check("blink_disabled", 101, 52, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 499) == 0);
      frame_start = ($urandom_range(0, 59) == 0);
      origin_x    = X_W'($urandom_range(0, 120));
      origin_y    = Y_W'($urandom_range(0, 60));
      scale       = 2'($urandom_range(0, 3));
      blink_en    = ($urandom_range(0, 3) == 0);
      text_we     = ($urandom_range(0, 15) == 0);
      text_waddr  = 4'($urandom);
      text_wdata  = CODE_W'($urandom);
      pix_valid   = ($urandom_range(0, 3) != 0);
      pix_x       = X_W'($urandom_range(0, 700));
      pix_y       = Y_W'($urandom_range(0, 200));
      step();
    end
    reset = 0; clear_strobes(); pix_valid = 0;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
